arbt_req_agent: RTL and testbench
=================================

Name: arbt_req_agent

Overview:
Requester-side agent for the 4-way fixed-priority arbiter's req/gnt protocol. One instance sits in front of each requester. Local logic pushes packets (beats with a last marker) into an internal FIFO. The agent raises req once a complete packet is stored, waits for the one-cycle gnt pulse, then streams that packet out on the shared bus and releases req.

Parameters:
DW, 8, payload width per beat
DEPTH, 8, FIFO depth in beats; power of 2, minimum 2
TIMEOUT, 64, cycles in REQ without gnt before req_timeout sets (used only with the optional feature)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  local beat valid
cmd_ready  output  1  FIFO can accept a beat (not full)
cmd_data  input  DW  local beat payload
cmd_last  input  1  beat is the last of a packet
req  output  1  request to arbiter, registered
gnt  input  1  grant pulse from arbiter, one cycle wide
bus_valid  output  1  beat on bus, registered
bus_data  output  DW  beat payload, registered
bus_last  output  1  last beat of packet, registered
stray_gnt  output  1  one-cycle pulse: gnt seen outside REQ
req_timeout  output  1  sticky: waited too long for gnt

Behaviour:
- Reset: req=0, bus_valid=0, bus_data=0, bus_last=0, stray_gnt=0, req_timeout=0. FIFO empty, pkt_cnt=0, state=IDLE. Asserting reset mid-packet discards all FIFO contents and aborts the transfer.
- FIFO: DEPTH entries of {last, data}. Write when cmd_valid && cmd_ready. cmd_ready = !full. Pointers are log2(DEPTH)+1 bits with wrap bit; full when addresses match and wrap bits differ.
- pkt_cnt counts complete packets held in the FIFO (log2(DEPTH)+1 bits):
  - +1 on a push with cmd_last=1.
  - -1 on a pop with last=1.
  - Both in the same cycle: no change.
- A packet longer than DEPTH beats is illegal; behaviour is undefined.
- FSM, all outputs registered:
  - IDLE: if pkt_cnt != 0, go to REQ with req<=1.
  - REQ: hold req=1. On gnt=1: req<=0, go to XFER. Data is popped starting the next cycle.
  - XFER: each cycle pop one beat and drive bus_valid<=1, bus_data, bus_last on the next edge. On the popped beat with last=1, go to GAP. The FIFO is never empty mid-packet because a complete packet was present.
  - GAP: one cycle with bus_valid<=0 and req=0, which guarantees the arbiter's arbt_time_d clears. Then go to REQ with req<=1 if pkt_cnt != 0, else IDLE.
- Latency: gnt sampled at edge N -> first bus beat valid after edge N+2. Beats are back-to-back; there is no bus stall.
- bus_valid deasserts the cycle after the last beat. bus_data holds its last value while bus_valid=0.
- Pushes continue during XFER. A new packet completed during XFER is requested after GAP.
- stray_gnt: asserted for one cycle when gnt=1 in IDLE, XFER or GAP. The gnt is otherwise ignored.
- Simultaneous push of last beat and pop of last beat: pkt_cnt unchanged, as above.

Optional Feature:
ARBT_REQ_TIMEOUT_EN:
- Defined:
  - A wait counter (width clog2(TIMEOUT+1)) clears on entry to REQ and increments each cycle in REQ without gnt.
  - When it reaches TIMEOUT, req_timeout<=1 and stays set until reset. req stays asserted; there is no abort.
- Undefined: no counter; req_timeout is tied to 0.

Test Plan:
- Single packet: push 3 beats 0xA1, 0xA2, 0xA3(last); req rises 1 cycle after the last push; gnt pulse -> req falls; bus emits A1, A2, A3 on consecutive cycles starting 2 cycles after gnt, with bus_last only on A3; req stays 0 through GAP.
- Back-to-back packets: push packet P0 (2 beats) and P1 (1 beat) before gnt; after P0 transfer, one GAP cycle with req=0, then req=1 again; second gnt -> P1 beat with bus_last=1.
- Full FIFO: DEPTH=8, push 8 beats (8th with last) -> cmd_ready=0; after gnt and the first pop, cmd_ready=1 the following cycle; wrap-around data integrity checked over 3 refills.
- Stray grant: gnt=1 in IDLE with empty FIFO -> stray_gnt pulses once; req stays 0; no bus beats.
- Reset mid-XFER: assert rst_n=0 during the 2nd of 4 beats -> bus_valid=0, req=0, cmd_ready=1 immediately; no residual beats after release.
- Timeout (ARBT_REQ_TIMEOUT_EN, TIMEOUT=64): packet queued, gnt withheld -> req_timeout=1 exactly 64 cycles after req rises; a later gnt completes the transfer and req_timeout stays 1.

Source files
------------

// File: rtl/arbt_req_agent.sv
// Requester-side agent for the 4-way fixed-priority arbiter: buffers local packets, requests, then streams on grant.
// Optional macro ARBT_REQ_TIMEOUT_EN adds a sticky req_timeout watchdog on the REQ wait.
module arbt_req_agent #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_data,
  input  logic          cmd_last,
  output logic          req,
  input  logic          gnt,
  output logic          bus_valid,
  output logic [DW-1:0] bus_data,
  output logic          bus_last,
  output logic          stray_gnt,
  output logic          req_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("arbt_req_agent: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  logic [DW:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW-1:0]  r_pkt_cnt;
  logic [1:0]     r_state;
  logic           r_req;
  logic           r_bus_valid;
  logic [DW-1:0]  r_bus_data;
  logic           r_bus_last;
  logic           r_stray;
  logic           r_arm;

  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic [DW:0]    w_head;
  logic [1:0]     w_state_nxt;
  logic           w_req_nxt;
  logic           w_bus_valid_nxt;
  logic [DW-1:0]  w_bus_data_nxt;
  logic           w_bus_last_nxt;
  logic           w_stray_nxt;
  logic           w_arm_nxt;

  assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  // Storage has no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_last, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push && cmd_last, w_pop && w_head[DW]})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // XFER spends its first cycle arming (r_arm) so the first beat lands two edges after gnt.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_bus_valid_nxt = 1'b0;
    w_bus_data_nxt  = r_bus_data;
    w_bus_last_nxt  = 1'b0;
    w_stray_nxt     = 1'b0;
    w_arm_nxt       = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stray_nxt = gnt;
        w_req_nxt   = 1'b0;
        if (r_pkt_cnt != '0) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
        end
      end
      S_REQ: begin
        w_req_nxt = 1'b1;
        if (gnt) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        w_stray_nxt = gnt;
        w_req_nxt   = 1'b0;
        w_arm_nxt   = 1'b1;
        if (r_arm) begin
          w_pop           = 1'b1;
          w_bus_valid_nxt = 1'b1;
          w_bus_data_nxt  = w_head[DW-1:0];
          w_bus_last_nxt  = w_head[DW];
          if (w_head[DW]) begin
            w_state_nxt = S_GAP;
            w_arm_nxt   = 1'b0;
          end
        end
      end
      S_GAP: begin
        w_stray_nxt = gnt;
        if (r_pkt_cnt != '0) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_bus_last  <= 1'b0;
      r_stray     <= 1'b0;
      r_arm       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_bus_valid <= w_bus_valid_nxt;
      r_bus_data  <= w_bus_data_nxt;
      r_bus_last  <= w_bus_last_nxt;
      r_stray     <= w_stray_nxt;
      r_arm       <= w_arm_nxt;
    end
  end

  assign req       = r_req;
  assign bus_valid = r_bus_valid;
  assign bus_data  = r_bus_data;
  assign bus_last  = r_bus_last;
  assign stray_gnt = r_stray;

`ifdef ARBT_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait;
  logic          r_req_timeout;

  // Flag is raised on the same edge the wait count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait        <= '0;
      r_req_timeout <= 1'b0;
    end else if (r_state != S_REQ) begin
      r_wait <= '0;
    end else if (!gnt) begin
      if (r_wait != TW'(TIMEOUT)) r_wait <= r_wait + TW'(1);
      if (r_wait == TW'(TIMEOUT - 1)) r_req_timeout <= 1'b1;
    end
  end

  assign req_timeout = r_req_timeout;
`else
  assign req_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arbt_req_agent.sv
// Self-checking bench for arbt_req_agent: directed scenarios plus randomized packets against a beat-queue model.
module tb_arbt_req_agent;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_last;
  logic       req;
  logic       gnt;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_last;
  logic       stray_gnt;
  logic       req_timeout;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

`ifdef ARBT_REQ_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  arbt_req_agent #(.DW(8), .DEPTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .req(req), .gnt(gnt),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
    .stray_gnt(stray_gnt), .req_timeout(req_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    cmd_valid = 1'b1; cmd_data = d; cmd_last = l;
    exp_q.push_back(beat_t'{last: l, data: d});
    tick();
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_last = 1'b0; gnt = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({req, bus_valid, bus_last, stray_gnt, req_timeout} !== 5'b0 || bus_data !== 8'h00 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset req=%b bv=%b bl=%b sg=%b to=%b bd=%h rdy=%b exp all 0, rdy=1",
               req, bus_valid, bus_last, stray_gnt, req_timeout, bus_data, cmd_ready);
    end
  endtask

  task automatic test_stray();
    gnt = 1'b1; tick(); gnt = 1'b0;
    checks++;
    if (stray_gnt !== 1'b1 || req !== 1'b0) begin
      errors++; $display("FAIL stray_pulse sg=%b req=%b exp sg=1 req=0", stray_gnt, req);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (stray_gnt !== 1'b0 || req !== 1'b0 || bus_valid !== 1'b0) begin
        errors++; $display("FAIL stray_after%0d sg=%b req=%b bv=%b exp 0 0 0", i, stray_gnt, req, bus_valid);
      end
    end
  endtask

  task automatic test_single();
    beat_t b;
    push_beat(8'hA1, 1'b0); push_beat(8'hA2, 1'b0); push_beat(8'hA3, 1'b1);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL single_req_early req=%b exp=0", req); end
    tick();
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL single_req_rise req=%b exp=1", req); end
    gnt = 1'b1; tick(); gnt = 1'b0;
    checks++;
    if (req !== 1'b0 || bus_valid !== 1'b0) begin
      errors++; $display("FAIL single_req_fall req=%b bv=%b exp 0 0", req, bus_valid);
    end
    tick();
    checks++;
    if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_latency bv=%b exp=0", bus_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      b = exp_q.pop_front();
      checks++;
      if (bus_valid !== 1'b1 || bus_data !== b.data || bus_last !== b.last || req !== 1'b0) begin
        errors++;
        $display("FAIL single_beat%0d bv=%b bd=%h bl=%b req=%b exp 1 %h %b 0", i, bus_valid, bus_data, bus_last, req, b.data, b.last);
      end
    end
    tick();
    checks++;
    if (bus_valid !== 1'b0 || req !== 1'b0 || bus_data !== 8'hA3) begin
      errors++; $display("FAIL single_gap bv=%b req=%b bd=%h exp 0 0 a3", bus_valid, req, bus_data);
    end
    tick();
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL single_idle req=%b exp=0", req); end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    push_beat(8'($urandom), 1'b0); push_beat(8'($urandom), 1'b1); push_beat(8'($urandom), 1'b1);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL b2b_req0 req=%b exp=1", req); end
    for (int p = 0; p < 2; p++) begin
      gnt = 1'b1; tick(); gnt = 1'b0;
      tick();
      for (int i = 0; i < 2 - p; i++) begin
        tick();
        b = exp_q.pop_front();
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== b.data || bus_last !== b.last || req !== 1'b0) begin
          errors++;
          $display("FAIL b2b_beat p%0d b%0d bv=%b bd=%h bl=%b req=%b exp 1 %h %b 0", p, i, bus_valid, bus_data, bus_last, req, b.data, b.last);
        end
      end
      tick();
      checks++;
      if (bus_valid !== 1'b0 || req !== (p == 0)) begin
        errors++; $display("FAIL b2b_gap p%0d bv=%b req=%b exp bv=0 req=%b", p, bus_valid, req, p == 0);
      end
    end
    tick();
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL b2b_idle req=%b exp=0", req); end
  endtask

  task automatic test_full();
    beat_t b;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) push_beat(8'($urandom), i == 7);
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready r%0d rdy=%b exp=0", r, cmd_ready); end
      tick();
      gnt = 1'b1; tick(); gnt = 1'b0;
      tick();
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold r%0d rdy=%b exp=0", r, cmd_ready); end
      for (int i = 0; i < 8; i++) begin
        tick();
        b = exp_q.pop_front();
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== b.data || bus_last !== b.last || cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_beat r%0d b%0d bv=%b bd=%h bl=%b rdy=%b exp 1 %h %b 1", r, i, bus_valid, bus_data, bus_last, cmd_ready, b.data, b.last);
        end
      end
      tick(); tick();
      checks++;
      if (bus_valid !== 1'b0 || req !== 1'b0) begin
        errors++; $display("FAIL full_end r%0d bv=%b req=%b exp 0 0", r, bus_valid, req);
      end
    end
  endtask

  // Packet A is already queued and requested; packet B is pushed on a random schedule while A is granted.
  task automatic test_random();
    int    len_a, len_b, tb_last, req_rise, t_end, e;
    int    sched[4];
    logic [7:0] bdat[4];
    beat_t b;
    logic  exp_v, exp_r;
    len_a = $urandom_range(1, 4);
    for (int i = 0; i < len_a; i++) push_beat(8'($urandom), i == len_a - 1);
    tick();
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL rand_first_req req=%b exp=1", req); end
    for (int it = 0; it < 25; it++) begin
      len_b = (it == 24) ? 0 : int'($urandom_range(1, 4));
      e = $urandom_range(0, 3);
      for (int i = 0; i < len_b; i++) begin
        e += $urandom_range(0, 1);
        sched[i] = e; bdat[i] = 8'($urandom);
        e++;
      end
      tb_last  = (len_b == 0) ? 1000 : sched[len_b-1];
      req_rise = (tb_last + 1 > len_a + 2) ? tb_last + 1 : len_a + 2;
      t_end    = ((len_b == 0) ? len_a + 2 : req_rise) + 1;
      for (int t = 0; t <= t_end; t++) begin
        gnt = (t == 0);
        cmd_valid = 1'b0; cmd_last = 1'b0;
        for (int i = 0; i < len_b; i++) begin
          if (sched[i] == t) begin
            cmd_valid = 1'b1; cmd_data = bdat[i]; cmd_last = (i == len_b - 1);
            exp_q.push_back(beat_t'{last: (i == len_b - 1), data: bdat[i]});
          end
        end
        tick();
        exp_v = (t >= 2 && t <= len_a + 1);
        exp_r = (t >= req_rise);
        b = '0;
        if (exp_v) b = exp_q.pop_front();
        checks++;
        if (bus_valid !== exp_v || (exp_v && (bus_data !== b.data || bus_last !== b.last))) begin
          errors++;
          $display("FAIL rand_bus it%0d t%0d bv=%b bd=%h bl=%b exp %b %h %b", it, t, bus_valid, bus_data, bus_last, exp_v, b.data, b.last);
        end
        checks++;
        if (req !== exp_r || stray_gnt !== 1'b0) begin
          errors++; $display("FAIL rand_req it%0d t%0d req=%b sg=%b exp %b 0", it, t, req, stray_gnt, exp_r);
        end
      end
      gnt = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
      len_a = len_b;
      if (len_b != 0) begin
        repeat ($urandom_range(0, 4)) begin
          tick();
          checks++;
          if (req !== 1'b1) begin errors++; $display("FAIL rand_hold it%0d req=%b exp=1", it, req); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    for (int i = 0; i < 4; i++) push_beat(8'($urandom), i == 3);
    for (int i = 0; i < 3; i++) push_beat(8'($urandom), 1'b0);
    gnt = 1'b1; tick(); gnt = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus_valid !== 1'b1 || bus_data !== exp_q[1].data) begin
      errors++; $display("FAIL rmid_beat2 bv=%b bd=%h exp 1 %h", bus_valid, bus_data, exp_q[1].data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_valid !== 1'b0 || req !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_async bv=%b req=%b rdy=%b exp 0 0 1", bus_valid, req, cmd_ready);
    end
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus_valid !== 1'b0 || req !== 1'b0) begin
        errors++; $display("FAIL rmid_residual%0d bv=%b req=%b exp 0 0", i, bus_valid, req);
      end
    end
    push_beat(8'h5C, 1'b1);
    tick();
    gnt = 1'b1; tick(); gnt = 1'b0;
    tick(); tick();
    b = exp_q.pop_front();
    checks++;
    if (bus_valid !== 1'b1 || bus_data !== b.data || bus_last !== 1'b1) begin
      errors++; $display("FAIL rmid_fresh bv=%b bd=%h bl=%b exp 1 %h 1", bus_valid, bus_data, bus_last, b.data);
    end
    tick();
    checks++;
    if (bus_valid !== 1'b0) begin errors++; $display("FAIL rmid_fresh_end bv=%b exp=0", bus_valid); end
    tick();
  endtask

  task automatic test_timeout();
    beat_t b;
    push_beat(8'($urandom), 1'b1);
    tick();
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) begin
        checks++;
        if (req_timeout !== 1'b0) begin errors++; $display("FAIL to_early to=%b exp=0", req_timeout); end
      end
      if (k == 64) begin
        checks++;
        if (req_timeout !== TO_EXP || req !== 1'b1) begin
          errors++; $display("FAIL to_set to=%b req=%b exp %b 1", req_timeout, req, TO_EXP);
        end
      end
    end
    gnt = 1'b1; tick(); gnt = 1'b0;
    tick(); tick();
    b = exp_q.pop_front();
    checks++;
    if (bus_valid !== 1'b1 || bus_data !== b.data || bus_last !== 1'b1) begin
      errors++; $display("FAIL to_xfer bv=%b bd=%h bl=%b exp 1 %h 1", bus_valid, bus_data, bus_last, b.data);
    end
    tick(); tick();
    checks++;
    if (req_timeout !== TO_EXP || req !== 1'b0) begin
      errors++; $display("FAIL to_sticky to=%b req=%b exp %b 0", req_timeout, req, TO_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_stray();
    test_single();
    test_back_to_back();
    test_full();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
